// File: rtl/msb_scan_param.sv
// -----------------------------------------------------------------------------
// msb_scan_param
//   Sequential first-set-bit search. A captured word is walked one CHUNK-bit
//   slice per cycle, from the top slice down (MSB mode) or from the bottom
//   slice up (LSB mode). The walk stops at the first nonzero slice and the
//   result is the 1-based bit position, or 0 with out_zero set when the word
//   is all zeros. Results are held in DONE until the consumer handshakes.
//
//   Optional feature macro: MSB_SCAN_POPCNT_EN
//     When defined, an out_popcnt port reports the number of set bits in the
//     captured word. The count is taken at the capture edge, so it is valid in
//     DONE whether or not the scan ended early.
// -----------------------------------------------------------------------------
module msb_scan_param #(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int PW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_pos,
  output logic             out_zero,
`ifdef MSB_SCAN_POPCNT_EN
  output logic [PW-1:0]    out_popcnt,
`endif
  output logic             busy
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CPW    = $clog2(CHUNK + 1);

  localparam logic [IW-1:0] FIRST_IDX = '0;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCHUNK - 1);

  // A word that does not split into whole slices would leave bits that are
  // never examined, so such a configuration must not elaborate.
  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("msb_scan_param: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  // Search direction of the captured request.
  localparam logic MODE_MSB = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // 1-based position of the highest set bit in a slice (0 if none).
  function automatic logic [CPW-1:0] slice_hi_pos(input logic [CHUNK-1:0] s);
    logic [CPW-1:0] p;
    p = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (s[i]) p = CPW'(i + 1);
    end
    return p;
  endfunction

  // 1-based position of the lowest set bit in a slice (0 if none).
  function automatic logic [CPW-1:0] slice_lo_pos(input logic [CHUNK-1:0] s);
    logic [CPW-1:0] p;
    p = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (s[i]) p = CPW'(i + 1);
    end
    return p;
  endfunction

`ifdef MSB_SCAN_POPCNT_EN
  // Number of set bits in a full word.
  function automatic logic [PW-1:0] word_popcnt(input logic [WIDTH-1:0] w);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + PW'(w[i]);
    end
    return c;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,  state_d;
  logic [WIDTH-1:0]  word_q,   word_d;
  logic              mode_q,   mode_d;
  logic [IW-1:0]     idx_q,    idx_d;
  logic [PW-1:0]     pos_q,    pos_d;
  logic              zero_q,   zero_d;
`ifdef MSB_SCAN_POPCNT_EN
  logic [PW-1:0]     popcnt_q, popcnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Datapath for the slice currently under examination
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0]  slice;
  logic              slice_nz;
  logic [CPW-1:0]    slice_pos;
  logic              idx_is_last;
  logic [IW-1:0]     idx_step;
  logic [PW-1:0]     found_pos;

  // Select the slice addressed by the index and locate its set bit.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    slice = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (idx_q == IW'(c)) slice = word_q[c*CHUNK +: CHUNK];
    end

    slice_nz    = |slice;
    slice_pos   = (mode_q == MODE_MSB) ? slice_hi_pos(slice) : slice_lo_pos(slice);

    // The boundary slice depends on direction; the scan never steps past it,
    // so the index stays inside 0..NCHUNK-1 without wrapping.
    idx_is_last = (mode_q == MODE_MSB) ? (idx_q == FIRST_IDX) : (idx_q == LAST_IDX);
    idx_step    = (mode_q == MODE_MSB) ? (idx_q - IW'(1)) : (idx_q + IW'(1));

    found_pos   = PW'(int'(idx_q) * CHUNK + int'(slice_pos));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Compute the FSM transition and the next value of every register.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    zero_d   = zero_q;
`ifdef MSB_SCAN_POPCNT_EN
    popcnt_d = popcnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d   = in_data;
          mode_d   = in_mode;
          idx_d    = (in_mode == MODE_MSB) ? LAST_IDX : FIRST_IDX;
`ifdef MSB_SCAN_POPCNT_EN
          popcnt_d = word_popcnt(in_data);
`endif
          state_d  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (slice_nz) begin
          pos_d   = found_pos;
          zero_d  = 1'b0;
          state_d = S_DONE;
        end else if (idx_is_last) begin
          pos_d   = '0;
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_step;
        end
      end

      S_DONE: begin
        // Result registers are untouched here, so they hold until the handshake.
        if (out_ready) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Single clocked process for the FSM and datapath, reset has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      // NOTE: the captured word is cleared on reset as well, so an aborted
      // request leaves no stale data behind for the next one.
      state_q  <= S_IDLE;
      word_q   <= '0;
      mode_q   <= MODE_MSB;
      idx_q    <= '0;
      pos_q    <= '0;
      zero_q   <= 1'b0;
`ifdef MSB_SCAN_POPCNT_EN
      popcnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      zero_q   <= zero_d;
`ifdef MSB_SCAN_POPCNT_EN
      popcnt_q <= popcnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight decodes of the state register and result registers
  // ---------------------------------------------------------------------------
  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_pos    = pos_q;
  assign out_zero   = zero_q;
`ifdef MSB_SCAN_POPCNT_EN
  assign out_popcnt = popcnt_q;
`endif

endmodule
